fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the single write port of the ADC sample FIFO between N_REQ frame sources.
//  Each source is a FIFO writer or PISO frame serialiser with a valid/ready word stream.
//  Sources are granted round-robin. A grant lasts one burst of BURST_LEN words.
//  FIFO back-pressure (WRFULL) is honoured, and a stalled source is aborted by watchdog.
//  Sits between the per-channel writers and the dual-clock FIFO write side (CLK domain).
// PARAMETERS
//  N_REQ      4   number of requesting sources (2..8)
//  DATA_W     64  FIFO word width
//  BURST_LEN  4   words per grant (one 4x64 frame); >=1
//  STALL_MAX  255 consecutive VALID-low cycles inside a burst before abort; >=1
// PORTS
//  CLK      in   1             system clock, all logic on posedge
//  RST      in   1             synchronous, active-high reset
//  REQ      in   N_REQ         source i has a frame ready (level)
//  VALID    in   N_REQ         source i presents a word on DIN[i]
//  DIN      in   N_REQ*DATA_W  packed data, source i at [i*DATA_W +: DATA_W]
//  READY    out  N_REQ         word accepted from source i this cycle
//  GNT      out  N_REQ         one-hot registered grant; 0 when not in BURST
//  WRFULL   in   1             FIFO full (write side)
//  WRREQ    out  1             FIFO write strobe
//  WRDATA   out  DATA_W        FIFO write data
//  ABORT    out  1             1-cycle pulse: burst aborted by watchdog
//  BUSY     out  1             state != IDLE
// BEHAVIOUR
//  Reset (RST=1 at posedge):
//   - state=IDLE, GNT=0, rr_ptr=0, beat_cnt=0, stall_cnt=0, ABORT=0.
//   - READY=0, WRREQ=0, WRDATA=0.
//   - Reset mid-burst drops the burst immediately. No write occurs in the reset cycle.
//  States:
//   - IDLE:  if |REQ, pick winner w and register GNT=onehot(w) -> BURST.
//            The pick is the first i with REQ[i] set, scanning from rr_ptr upward modulo N_REQ.
//            Latency: REQ high -> GNT high next cycle. The first write can occur in that cycle.
//   - BURST: READY[g] = ~WRFULL; all other READY bits are 0.
//            WRREQ = VALID[g] & ~WRFULL (combinational from registered GNT).
//            WRDATA = DIN[g] when WRREQ; otherwise WRDATA holds its last written value.
//            Each WRREQ: beat_cnt++, stall_cnt=0.
//            WRREQ with beat_cnt==BURST_LEN-1 -> DONE.
//            A cycle with VALID[g]=0 increments stall_cnt.
//            WRFULL cycles with VALID=1 do not count toward the stall limit.
//            stall_cnt==STALL_MAX-1 with VALID[g]=0 -> ABORT pulse next cycle, -> DONE.
//   - DONE:  GNT=0, WRREQ=0, rr_ptr=(g+1) mod N_REQ, beat_cnt=0, stall_cnt=0 -> IDLE.
//            One dead cycle between bursts is required; the FIFO sees a gap.
//  Grant rules:
//   - REQ is sampled only in IDLE. Deasserting REQ mid-burst does not end the burst.
//   - Ending a burst early is only possible via the watchdog.
//  Simultaneous events:
//   - Last beat and WRFULL rising in the same cycle: the write is gated by WRFULL.
//     The burst stays in BURST until the beat is accepted.
//   - All REQ high: strict rotation 0,1,2,3,0,...
//  Fairness: with every source requesting continuously, no source waits more than N_REQ-1 bursts.
//  WRREQ is never high while WRFULL=1. READY and WRREQ always agree for the granted source.
//  Widths: beat_cnt $clog2(BURST_LEN+1); stall_cnt $clog2(STALL_MAX+1), saturating.
//          rr_ptr $clog2(N_REQ).
// STRUCTURE
//  Package fifo_arb_pkg:
//   - arb_state_t enum {IDLE, BURST, DONE}, one-hot encoded.
//   - function onehot2idx().
//   - default constants N_REQ_DEF=4, DATA_W_DEF=64.
//  Sub-module rr_priority_select:
//   - combinational rotate-and-find-first of REQ from rr_ptr.
//   - outputs a one-hot winner plus an any-bit.
//  Top: FSM, counters, data mux.
// TESTING
//  1. Single source: REQ[2]=1, VALID[2]=1 for 4 beats, WRFULL=0.
//     -> GNT=4'b0100 one cycle later; WRREQ for exactly 4 cycles; DONE gap; rr_ptr=3.
//  2. All REQ=4'hF held for 8 bursts.
//     -> grant order 0,1,2,3,0,1,2,3; 32 WRREQ total; WRDATA matches each source's sequence.
//  3. WRFULL high for 10 cycles after beat 1.
//     -> WRREQ=0 and READY=0 for those cycles; no ABORT; burst resumes and completes 4 beats.
//  4. Watchdog with STALL_MAX=8: VALID drops after beat 2.
//     -> ABORT pulse after 8 idle cycles; GNT clears; next requester is granted.
//  5. RST=1 asserted during beat 3.
//     -> next cycle all outputs 0, state IDLE; after release, grant restarts from source 0.
//  6. REQ[1] deasserted mid-burst.
//     -> burst still completes BURST_LEN beats; source 1 is not re-granted while REQ[1]=0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types, default constants and helpers for the FIFO
//               write-port arbiter.
//               Contents:
//                 N_REQ_DEF, DATA_W_DEF  default source count / word width
//                 arb_state_t            one-hot arbiter FSM state
//                 onehot2idx()           one-hot (up to 8 bits) -> index
// Revision    : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    BURST = 3'b010,
    DONE  = 3'b100
  } arb_state_t;

  // Index of the set bit in a one-hot vector of up to 8 sources.
  // Returns 0 for an all-zero vector.
  function automatic int onehot2idx(input logic [7:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i[2:0]]) idx = i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_select
// Description : Combinational round-robin pick. Finds the first set request
//               bit scanning upward from i_rr_ptr, wrapping modulo N_REQ.
//               Ports:
//                 i_req      [N_REQ-1:0]  request vector
//                 i_rr_ptr   [PTR_W-1:0]  index with highest priority
//                 o_win_oh   [N_REQ-1:0]  one-hot winner (0 when no request)
//                 o_win_any               at least one request present
// Revision    : 1.0  initial release
// ============================================================================
module rr_priority_select
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PTR_W = $clog2(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_rr_ptr,
  output logic [N_REQ-1:0] o_win_oh,
  output logic             o_win_any
);

  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_first;

  always_comb begin
    // Rotate so that bit 0 of w_rot is request i_rr_ptr.
    w_rot    = N_REQ'({i_req, i_req} >> i_rr_ptr);
    // Isolate the lowest set bit of the rotated vector.
    w_first  = w_rot & (~w_rot + 1'b1);
    // Rotate back: the upper half of the shifted doubled vector holds the
    // winner in original bit positions, wrap-around included.
    o_win_oh = N_REQ'(({w_first, w_first} << i_rr_ptr) >> N_REQ);
    o_win_any = |i_req;
  end

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Shares the single write port of the ADC sample FIFO between
//               N_REQ word-stream sources. Round-robin grant of one burst of
//               BURST_LEN words, honours WRFULL, and aborts a burst whose
//               source stops presenting data for STALL_MAX cycles.
//               Ports:
//                 CLK, RST           clock, synchronous active-high reset
//                 REQ   [N_REQ]      source has a frame ready (level)
//                 VALID [N_REQ]      source presents a word
//                 DIN   [N_REQ*DW]   packed source words, i at [i*DW +: DW]
//                 READY [N_REQ]      word accepted from source this cycle
//                 GNT   [N_REQ]      registered one-hot grant (BURST only)
//                 WRFULL             FIFO full
//                 WRREQ, WRDATA      FIFO write strobe / data
//                 ABORT              one-cycle watchdog abort pulse
//                 BUSY               FSM not idle
// Revision    : 1.0  initial release
// ============================================================================
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = 4,
  parameter int STALL_MAX = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [N_REQ-1:0]        VALID,
  input  logic [N_REQ*DATA_W-1:0] DIN,
  output logic [N_REQ-1:0]        READY,
  output logic [N_REQ-1:0]        GNT,
  input  logic                    WRFULL,
  output logic                    WRREQ,
  output logic [DATA_W-1:0]       WRDATA,
  output logic                    ABORT,
  output logic                    BUSY
);

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int BEAT_W  = $clog2(BURST_LEN + 1);
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  localparam logic [BEAT_W-1:0]  C_LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [STALL_W-1:0] C_STALL_LAST = STALL_W'(STALL_MAX - 1);
  localparam logic [STALL_W-1:0] C_STALL_SAT  = STALL_W'(STALL_MAX);

  arb_state_t          state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                abort_q, abort_d;
  logic [DATA_W-1:0]   wrdata_q, wrdata_d;

  logic [N_REQ-1:0]              w_win_oh;
  logic                          w_win_any;
  logic [7:0]                    w_gnt_ext;
  logic [PTR_W-1:0]              w_gnt_idx;
  logic [PTR_W-1:0]              w_next_ptr;
  logic [N_REQ-1:0][DATA_W-1:0]  w_din_arr;
  logic [DATA_W-1:0]             w_din_sel;
  logic                          w_valid_sel;
  logic                          w_wr_en;
  logic [N_REQ-1:0]              w_ready;

  rr_priority_select #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_sel (
    .i_req     (REQ),
    .i_rr_ptr  (rr_ptr_q),
    .o_win_oh  (w_win_oh),
    .o_win_any (w_win_any)
  );

  assign w_din_arr = DIN;

  // Granted-source selection, derived from the registered grant only.
  always_comb begin
    w_gnt_ext = '0;
    w_gnt_ext[N_REQ-1:0] = gnt_q;
    w_gnt_idx   = PTR_W'(onehot2idx(w_gnt_ext));
    w_next_ptr  = (int'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
    w_din_sel   = w_din_arr[w_gnt_idx];
    w_valid_sel = |(VALID & gnt_q);
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    abort_d     = 1'b0;
    wrdata_d    = wrdata_q;
    w_ready     = '0;
    w_wr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (w_win_any) begin
          gnt_d   = w_win_oh;
          state_d = BURST;
        end
      end

      BURST: begin
        // RST gating keeps the reset cycle free of any handshake.
        w_ready = gnt_q & {N_REQ{~WRFULL & ~RST}};
        w_wr_en = w_valid_sel & ~WRFULL & ~RST;
        if (w_wr_en) begin
          wrdata_d    = w_din_sel;
          stall_cnt_d = '0;
          beat_cnt_d  = beat_cnt_q + 1'b1;
          if (beat_cnt_q == C_LAST_BEAT) begin
            state_d  = DONE;
            gnt_d    = '0;
            rr_ptr_d = w_next_ptr;
          end
        end else if (!w_valid_sel) begin
          // Only VALID-low cycles count; a full FIFO never trips the watchdog.
          if (stall_cnt_q == C_STALL_LAST) begin
            abort_d  = 1'b1;
            state_d  = DONE;
            gnt_d    = '0;
            rr_ptr_d = w_next_ptr;
          end else if (stall_cnt_q != C_STALL_SAT) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        gnt_d       = '0;
        beat_cnt_d  = '0;
        stall_cnt_d = '0;
        state_d     = IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
      abort_q     <= 1'b0;
      wrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      abort_q     <= abort_d;
      wrdata_q    <= wrdata_d;
    end
  end

  assign READY  = w_ready;
  assign GNT    = gnt_q;
  assign WRREQ  = w_wr_en;
  assign WRDATA = w_wr_en ? w_din_sel : wrdata_q;
  assign ABORT  = abort_q;
  assign BUSY   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Self-checking bench for fifo_write_arbiter. Source models
//               emit {source index, word sequence number}; expected FIFO
//               words are queued when a scenario starts and popped on WRREQ.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int BL = 4;
  localparam int SM = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     valid;
  logic [N*W-1:0]   din;
  logic [N-1:0]     ready;
  logic [N-1:0]     gnt;
  logic             wrfull;
  logic             wrreq;
  logic [W-1:0]     wrdata;
  logic             abort;
  logic             busy;

  logic [31:0]      seq [N];
  logic [W-1:0]     exp_q [$];
  logic [W-1:0]     exp_word;
  logic [N-1:0]     exp_ready;

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int abort_count = 0;

  fifo_write_arbiter #(
    .N_REQ     (N),
    .DATA_W    (W),
    .BURST_LEN (BL),
    .STALL_MAX (SM)
  ) u_dut (
    .CLK    (clk),
    .RST    (rst),
    .REQ    (req),
    .VALID  (valid),
    .DIN    (din),
    .READY  (ready),
    .GNT    (gnt),
    .WRFULL (wrfull),
    .WRREQ  (wrreq),
    .WRDATA (wrdata),
    .ABORT  (abort),
    .BUSY   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int src, input logic [31:0] n);
    return {src[31:0], n};
  endfunction

  // Source models: each advances its word counter on an accepted handshake.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) seq[i] <= '0;
      else if (ready[i] && valid[i]) seq[i] <= seq[i] + 1;
    end
  end

  always_comb begin
    din = '0;
    for (int i = 0; i < N; i++) din[i*W +: W] = {i[31:0], seq[i]};
  end

  // Scoreboard and protocol monitor.
  always @(negedge clk) begin
    if (abort === 1'b1) abort_count++;
    if (wrreq === 1'b1) begin
      wr_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_write: got wrdata=%h, required no write", wrdata);
      end else begin
        exp_word = exp_q.pop_front();
        if (wrdata !== exp_word) begin
          bad++;
          $display("FAIL sb_wrdata: got %h, required %h", wrdata, exp_word);
        end
      end
    end
    if (wrfull === 1'b1) begin
      total++;
      if (wrreq !== 1'b0) begin
        bad++;
        $display("FAIL wrreq_while_full: got wrreq=%b, required 0", wrreq);
      end
    end
    if (gnt !== '0) begin
      exp_ready = (rst || wrfull) ? '0 : gnt;
      total++;
      if (ready !== exp_ready) begin
        bad++;
        $display("FAIL ready_vs_gnt: got ready=%b, required %b", ready, exp_ready);
      end
    end
  end

  // Bounded wait until GNT becomes non-zero (want=1) or zero (want=0).
  task automatic wait_gnt(input bit want);
    int w;
    w = 0;
    while (((gnt !== '0) != want) && w < 40) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; valid = '0; wrfull = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b, required 0000", gnt); end
    total++; if (wrreq !== 1'b0) begin bad++; $display("FAIL reset_wrreq: got %b, required 0", wrreq); end
    total++; if (ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b, required 0000", ready); end
    total++; if (wrdata !== '0) begin bad++; $display("FAIL reset_wrdata: got %h, required 0", wrdata); end
    total++; if (abort !== 1'b0) begin bad++; $display("FAIL reset_abort: got %b, required 0", abort); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    @(posedge clk); #1;
    for (int k = 0; k < BL; k++) exp_q.push_back(mk(2, seq[2] + k));
    req = 4'b0100; valid = 4'b0100;
    @(negedge clk);
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_gnt_idle: got %b, required 0000", gnt); end
    n = 0;
    for (int k = 0; k < BL; k++) begin
      @(negedge clk);
      total++;
      if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt beat%0d: got %b, required 0100", k, gnt); end
      if (wrreq === 1'b1) n++;
    end
    req = '0;
    total++; if (n != BL) begin bad++; $display("FAIL single_beats: got %0d, required %0d", n, BL); end
    @(negedge clk);
    total++;
    if ({busy, gnt, wrreq} !== 6'b1_0000_0) begin
      bad++; $display("FAIL single_done_gap: got busy/gnt/wrreq=%b, required 1_0000_0", {busy, gnt, wrreq});
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b, required 0", busy); end
    valid = '0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_all_req();
    int start;
    int src;
    int wr0;
    logic [31:0] nxt [N];
    logic [N-1:0] exp_g;
    start = 3;  // source 2 was served last
    for (int i = 0; i < N; i++) nxt[i] = seq[i];
    for (int b = 0; b < 8; b++) begin
      src = (start + b) % N;
      for (int k = 0; k < BL; k++) begin
        exp_q.push_back(mk(src, nxt[src]));
        nxt[src] = nxt[src] + 1;
      end
    end
    wr0 = wr_count;
    @(posedge clk); #1;
    req = 4'hF; valid = 4'hF;
    for (int b = 0; b < 8; b++) begin
      exp_g = 4'(1 << ((start + b) % N));
      wait_gnt(1'b1);
      total++;
      if (gnt !== exp_g) begin bad++; $display("FAIL all_grant_order burst%0d: got %b, required %b", b, gnt, exp_g); end
      if (b == 7) req = '0;
      wait_gnt(1'b0);
    end
    total++; if (gnt !== '0) begin bad++; $display("FAIL all_release: got gnt=%b, required 0000", gnt); end
    total++;
    if (wr_count - wr0 != 8 * BL) begin bad++; $display("FAIL all_write_count: got %0d, required %0d", wr_count - wr0, 8 * BL); end
    valid = '0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL all_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_wrfull();
    int wr0;
    int ab0;
    wr0 = wr_count; ab0 = abort_count;
    for (int k = 0; k < BL; k++) exp_q.push_back(mk(0, seq[0] + k));
    @(posedge clk); #1;
    req = 4'b0001; valid = 4'b0001;
    wait_gnt(1'b1);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wrfull_grant: got %b, required 0001", gnt); end
    req = '0;
    @(posedge clk); #1;              // beat 1 written in this cycle
    @(posedge clk); #1;
    wrfull = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if ({wrreq, ready, abort, gnt} !== {6'b0, 4'b0001}) begin
        bad++; $display("FAIL wrfull_hold cycle%0d: got wrreq/ready/abort/gnt=%b, required 000000_0001", c, {wrreq, ready, abort, gnt});
      end
      @(posedge clk); #1;
    end
    wrfull = 1'b0;
    wait_gnt(1'b0);
    total++; if (gnt !== '0) begin bad++; $display("FAIL wrfull_release: got gnt=%b, required 0000", gnt); end
    total++; if (wr_count - wr0 != BL) begin bad++; $display("FAIL wrfull_beats: got %0d, required %0d", wr_count - wr0, BL); end
    total++; if (abort_count != ab0) begin bad++; $display("FAIL wrfull_no_abort: got %0d aborts, required 0", abort_count - ab0); end
    valid = '0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrfull_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_watchdog();
    int ab0;
    ab0 = abort_count;
    exp_q.push_back(mk(1, seq[1]));
    exp_q.push_back(mk(1, seq[1] + 1));
    @(posedge clk); #1;
    req = 4'b0010; valid = 4'b0010;
    wait_gnt(1'b1);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL wd_grant: got %b, required 0010", gnt); end
    @(posedge clk); #1;              // beat 1
    @(posedge clk); #1;
    for (int k = 0; k < BL; k++) exp_q.push_back(mk(3, seq[3] + k));
    valid = 4'b1000; req = 4'b1000;
    for (int c = 0; c < SM; c++) begin
      @(negedge clk);
      total++;
      if ({abort, gnt} !== 5'b0_0010) begin bad++; $display("FAIL wd_stall cycle%0d: got abort/gnt=%b, required 0_0010", c, {abort, gnt}); end
    end
    @(negedge clk);
    total++; if ({abort, gnt} !== 5'b1_0000) begin bad++; $display("FAIL wd_abort: got abort/gnt=%b, required 1_0000", {abort, gnt}); end
    @(negedge clk);
    total++; if (abort !== 1'b0) begin bad++; $display("FAIL wd_pulse_width: got abort=%b, required 0", abort); end
    @(negedge clk);
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL wd_next_grant: got %b, required 1000", gnt); end
    req = '0;
    wait_gnt(1'b0);
    valid = '0;
    total++; if (abort_count - ab0 != 1) begin bad++; $display("FAIL wd_abort_count: got %0d, required 1", abort_count - ab0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wd_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(mk(2, seq[2]));
    exp_q.push_back(mk(2, seq[2] + 1));
    @(posedge clk); #1;
    req = 4'b0100; valid = 4'b0100;
    wait_gnt(1'b1);
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rstmid_grant: got %b, required 0100", gnt); end
    @(posedge clk); #1;              // beat 2
    @(posedge clk); #1;
    rst = 1'b1;                      // beat 3 would be written here
    @(negedge clk);
    total++; if ({wrreq, ready} !== 5'b0) begin bad++; $display("FAIL rstmid_no_write: got wrreq/ready=%b, required 00000", {wrreq, ready}); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < BL; k++) exp_q.push_back(mk(0, seq[0] + k));
    req = 4'hF; valid = 4'hF;
    @(negedge clk);
    total++;
    if ({busy, gnt, wrreq, ready, abort} !== 11'b0) begin
      bad++; $display("FAIL rstmid_outputs: got busy/gnt/wrreq/ready/abort=%b, required all 0", {busy, gnt, wrreq, ready, abort});
    end
    total++; if (wrdata !== '0) begin bad++; $display("FAIL rstmid_wrdata: got %h, required 0", wrdata); end
    @(negedge clk);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rstmid_restart: got %b, required 0001", gnt); end
    req = '0;
    wait_gnt(1'b0);
    valid = '0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rstmid_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_req_drop();
    int wr0;
    bit regrant;
    wr0 = wr_count;
    for (int k = 0; k < BL; k++) exp_q.push_back(mk(1, seq[1] + k));
    @(posedge clk); #1;
    req = 4'b0010; valid = 4'b0010;
    wait_gnt(1'b1);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL drop_grant: got %b, required 0010", gnt); end
    @(posedge clk); #1;
    req = '0;
    wait_gnt(1'b0);
    total++; if (wr_count - wr0 != BL) begin bad++; $display("FAIL drop_beats: got %0d, required %0d", wr_count - wr0, BL); end
    regrant = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (gnt !== '0) regrant = 1'b1;
    end
    total++; if (regrant) begin bad++; $display("FAIL drop_no_regrant: got a grant, required none"); end
    valid = '0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drop_sb_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; req = '0; valid = '0; wrfull = 1'b0;
    test_reset();
    test_single();
    test_all_req();
    test_wrfull();
    test_watchdog();
    test_reset_mid();
    test_req_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
